modport_router: RTL and testbench



---
 rtl/modport_router_pkg.sv | 25 ++
 rtl/modport_router_if.sv | 30 +++
 rtl/modport_router_fifo.sv | 65 ++++++
 rtl/modport_router.sv | 171 +++++++++++++++++
 tb/tb_modport_router.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/modport_router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : router_pkg
// Description : Shared types and constants for the 1-in / 3-out packet router.
// Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

    localparam int DEFAULT_DEPTH = 16;
    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] ADDR_INVALID      = 2'd3;
    localparam int         SOFT_RESET_CYCLES = 30;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_EMPTY = 3'd1,
        ST_PAYLOAD    = 3'd2,
        ST_FULL_WAIT  = 3'd3,
        ST_CHECK      = 3'd4,
        ST_DROP       = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/modport_router_if.sv
`default_nettype none
// ============================================================================
// Module      : modport_router_if
// Description : Source and sink bundle of the packet router.
// Revision    : 1.0 - initial release
// ============================================================================
interface modport_router_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             pkt_valid;
    logic             busy;
    logic             error;
    logic             read_enb_0, read_enb_1, read_enb_2;
    logic             vld_out_0, vld_out_1, vld_out_2;
    logic [WIDTH-1:0] data_out_0, data_out_1, data_out_2;

    modport slave (
        input  data_in, pkt_valid, read_enb_0, read_enb_1, read_enb_2,
        output busy, error, vld_out_0, vld_out_1, vld_out_2,
        output data_out_0, data_out_1, data_out_2
    );

    modport master (
        output data_in, pkt_valid, read_enb_0, read_enb_1, read_enb_2,
        input  busy, error, vld_out_0, vld_out_1, vld_out_2,
        input  data_out_0, data_out_1, data_out_2
    );
endinterface
`default_nettype wire

// File: rtl/modport_router_fifo.sv
`default_nettype none
// ============================================================================
// Module      : router_fifo
// Description : Synchronous FIFO with registered read data and a flush input.
// Revision    : 1.0 - initial release
// ============================================================================
module router_fifo
    import router_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_soft_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_empty,
    output logic             o_full
);
    localparam int             c_aw   = $clog2(DEPTH);
    localparam logic [c_aw:0]  c_full = (c_aw + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wptr, r_rptr;
    logic [c_aw:0]    r_count;
    logic             w_do_push, w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_full);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    // A flush behaves exactly like reset for this FIFO only.
    always_ff @(posedge clk) begin
        if (rst || i_soft_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            o_dout  <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
                o_dout <= r_mem[r_rptr];
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/modport_router.sv
`default_nettype none
// ============================================================================
// Module      : modport_router
// Description : 1-in / 3-out byte-serial packet router with parity checking.
//               Optional ROUTER_SOFT_RESET_EN flushes FIFOs left unread.
// Revision    : 1.0 - initial release
// ============================================================================
module modport_router
    import router_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic            clock,
    input  logic            resetn,
    modport_router_if.slave bus
);
    state_t           r_state, w_next;
    logic [1:0]       r_addr, w_in_addr, w_wr_addr;
    logic [WIDTH-1:0] r_hdr, r_parity, w_wr_data;
    logic             r_error;
    logic             w_wr, w_start, w_latch, w_acc, w_chk, w_busy;
    logic [2:0]       w_push, w_pop_req, w_empty, w_full, w_soft;
    logic [WIDTH-1:0] w_dout [3];

    assign w_in_addr = bus.data_in[1:0];
    assign w_pop_req = {bus.read_enb_2, bus.read_enb_1, bus.read_enb_0};
    assign w_wr_addr = (r_state == ST_IDLE) ? w_in_addr : r_addr;

    always_comb begin
        w_next    = r_state;
        w_wr      = 1'b0;
        w_wr_data = bus.data_in;
        w_busy    = 1'b0;
        w_start   = 1'b0;
        w_latch   = 1'b0;
        w_acc     = 1'b0;
        w_chk     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.pkt_valid) begin
                    if (w_in_addr == ADDR_INVALID) begin
                        w_next = ST_DROP;
                    end else if (w_empty[w_in_addr]) begin
                        w_wr    = 1'b1;
                        w_start = 1'b1;
                        w_next  = ST_PAYLOAD;
                    end else begin
                        w_latch = 1'b1;
                        w_next  = ST_WAIT_EMPTY;
                    end
                end
            end
            ST_WAIT_EMPTY: begin
                w_busy = 1'b1;
                if (w_empty[r_addr]) begin
                    w_wr      = 1'b1;
                    w_wr_data = r_hdr;
                    w_start   = 1'b1;
                    w_next    = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (w_full[r_addr]) begin
                    w_busy = 1'b1;
                    w_next = ST_FULL_WAIT;
                end else begin
                    w_wr = 1'b1;
                    if (bus.pkt_valid) begin
                        w_acc = 1'b1;
                    end else begin
                        w_chk  = 1'b1;
                        w_next = ST_CHECK;
                    end
                end
            end
            ST_FULL_WAIT: begin
                w_busy = 1'b1;
                if (!w_full[r_addr]) begin
                    w_next = ST_PAYLOAD;
                end
            end
            ST_CHECK: begin
                w_busy = 1'b1;
                w_next = ST_IDLE;
            end
            ST_DROP: begin
                if (!bus.pkt_valid) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (resetn) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_hdr    <= '0;
            r_parity <= '0;
            r_error  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_latch || w_start) begin
                r_addr <= w_wr_addr;
            end
            if (w_latch) begin
                r_hdr <= bus.data_in;
            end
            // The header seeds the running parity and starts a fresh error window.
            if (w_start) begin
                r_parity <= w_wr_data;
                r_error  <= 1'b0;
            end
            if (w_acc) begin
                r_parity <= r_parity ^ bus.data_in;
            end
            if (w_chk) begin
                r_error <= (bus.data_in != r_parity);
            end
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_port
        assign w_push[gi] = w_wr && (w_wr_addr == 2'(gi));

        router_fifo #(
            .DEPTH (DEPTH),
            .WIDTH (WIDTH)
        ) u_fifo (
            .clk        (clock),
            .rst        (resetn),
            .i_soft_rst (w_soft[gi]),
            .i_push     (w_push[gi]),
            .i_din      (w_wr_data),
            .i_pop      (w_pop_req[gi]),
            .o_dout     (w_dout[gi]),
            .o_empty    (w_empty[gi]),
            .o_full     (w_full[gi])
        );

`ifdef ROUTER_SOFT_RESET_EN
        logic [4:0] r_timer;
        logic       w_idle_hold;

        assign w_idle_hold = !w_empty[gi] && !w_pop_req[gi];
        assign w_soft[gi]  = w_idle_hold && (r_timer == 5'(SOFT_RESET_CYCLES - 1));

        always_ff @(posedge clock) begin
            if (resetn || w_soft[gi] || !w_idle_hold) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end
        end
`else
        assign w_soft[gi] = 1'b0;
`endif
    end

    assign bus.busy       = w_busy;
    assign bus.error      = r_error;
    assign bus.vld_out_0  = !w_empty[0];
    assign bus.vld_out_1  = !w_empty[1];
    assign bus.vld_out_2  = !w_empty[2];
    assign bus.data_out_0 = w_dout[0];
    assign bus.data_out_1 = w_dout[1];
    assign bus.data_out_2 = w_dout[2];
endmodule
`default_nettype wire

// File: tb/tb_modport_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_modport_router
// Description : Self-checking bench for modport_router (scoreboard per port).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_modport_router;
    logic clock = 1'b0;
    logic resetn;

    always #5 clock = ~clock;

    modport_router_if #(.WIDTH(8)) bus ();

    modport_router #(
        .DEPTH (16),
        .WIDTH (8)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    typedef struct {
        logic [1:0] addr;
        int         len;
        logic [7:0] seed;
        logic       bad;
        logic       exp_err;
    } vec_t;

    vec_t       vecs [6];
    logic [7:0] exp_q [3][$];
    int         n_cmp = 0;
    int         n_fail = 0;
    int         sent_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic get_vld(input int p);
        case (p)
            0:       return bus.vld_out_0;
            1:       return bus.vld_out_1;
            default: return bus.vld_out_2;
        endcase
    endfunction

    function automatic logic [7:0] get_dout(input int p);
        case (p)
            0:       return bus.data_out_0;
            1:       return bus.data_out_1;
            default: return bus.data_out_2;
        endcase
    endfunction

    task automatic set_rd(input int p, input logic v);
        case (p)
            0:       bus.read_enb_0 = v;
            1:       bus.read_enb_1 = v;
            default: bus.read_enb_2 = v;
        endcase
    endtask

    // Present one byte and hold it until the router takes it (busy low at the edge).
    task automatic drive_byte(input logic [7:0] b, input logic v);
        int g;
        bus.data_in   = b;
        bus.pkt_valid = v;
        g = 0;
        @(negedge clock);
        while (bus.busy && g < 200) begin
            @(negedge clock);
            g++;
        end
        if (bus.busy) check("drive_busy_timeout", 32'd1, 32'd0);
        @(posedge clock);
        #1;
        sent_count++;
    endtask

    task automatic send_pkt(input logic [1:0] a, input int len, input logic [7:0] seed,
                            input logic bad, input logic track);
        logic [7:0] hdr, b, par;
        hdr = {len[5:0], a};
        par = hdr;
        if (track) exp_q[a].push_back(hdr);
        drive_byte(hdr, 1'b1);
        for (int j = 0; j < len; j++) begin
            b   = seed + 8'(j * 17);
            par = par ^ b;
            if (track) exp_q[a].push_back(b);
            drive_byte(b, 1'b1);
        end
        b = par ^ {7'd0, bad};
        if (track) exp_q[a].push_back(b);
        drive_byte(b, 1'b0);
        bus.pkt_valid = 1'b0;
        bus.data_in   = 8'h00;
    endtask

    task automatic read_port(input int p, input int n);
        logic [7:0] e;
        int g;
        for (int k = 0; k < n; k++) begin
            g = 0;
            while (!get_vld(p) && g < 100) begin
                @(posedge clock);
                #1;
                g++;
            end
            if (!get_vld(p)) begin
                check($sformatf("port%0d_vld_timeout", p), 32'd0, 32'd1);
                return;
            end
            set_rd(p, 1'b1);
            @(posedge clock);
            #1;
            set_rd(p, 1'b0);
            if (exp_q[p].size() == 0) begin
                check("scoreboard_underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q[p].pop_front();
                check($sformatf("port%0d_byte%0d", p, k), get_dout(p), e);
            end
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic seen;
        vecs[0] = '{2'd1, 3, 8'h11, 1'b0, 1'b0};
        vecs[1] = '{2'd1, 3, 8'h11, 1'b1, 1'b1};
        vecs[2] = '{2'd0, 0, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{2'd2, 5, 8'hC3, 1'b1, 1'b1};
        vecs[4] = '{2'd2, 1, 8'h7E, 1'b0, 1'b0};
        vecs[5] = '{2'd0, 7, 8'h05, 1'b0, 1'b0};

        bus.data_in    = 8'h00;
        bus.pkt_valid  = 1'b0;
        bus.read_enb_0 = 1'b0;
        bus.read_enb_1 = 1'b0;
        bus.read_enb_2 = 1'b0;

        resetn = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b0;
        check("rst_busy", bus.busy, 0);
        check("rst_error", bus.error, 0);
        check("rst_vld", {bus.vld_out_2, bus.vld_out_1, bus.vld_out_0}, 0);
        check("rst_dout", {bus.data_out_2, bus.data_out_1, bus.data_out_0}, 0);

        for (int i = 0; i < 6; i++) begin
            send_pkt(vecs[i].addr, vecs[i].len, vecs[i].seed, vecs[i].bad, 1'b1);
            check($sformatf("vec%0d_error", i), bus.error, vecs[i].exp_err);
            check($sformatf("vec%0d_vld", i), get_vld(int'(vecs[i].addr)), 1);
            read_port(int'(vecs[i].addr), vecs[i].len + 2);
            check($sformatf("vec%0d_drained", i), get_vld(int'(vecs[i].addr)), 0);
        end

        // Bad parity, then a dropped packet must leave error set.
        send_pkt(2'd1, 2, 8'h33, 1'b1, 1'b1);
        read_port(1, 4);
        check("bad_error_set", bus.error, 1);
        send_pkt(2'd3, 2, 8'h77, 1'b0, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        check("drop_error_kept", bus.error, 1);
        check("drop_no_vld", {bus.vld_out_2, bus.vld_out_1, bus.vld_out_0}, 0);
        check("drop_busy", bus.busy, 0);

        // Error clears as soon as the next header is accepted.
        exp_q[0].push_back(8'h04);
        drive_byte(8'h04, 1'b1);
        check("err_clear_on_hdr", bus.error, 0);
        exp_q[0].push_back(8'hA5);
        drive_byte(8'hA5, 1'b1);
        exp_q[0].push_back(8'hA1);
        drive_byte(8'hA1, 1'b0);
        bus.pkt_valid = 1'b0;
        check("hdr_pkt_error", bus.error, 0);
        read_port(0, 3);

        // 20-byte payload into a 16-deep FIFO: stall, then drain with no loss.
        sent_count = 0;
        fork
            send_pkt(2'd0, 20, 8'h21, 1'b0, 1'b1);
            begin
                seen = 1'b0;
                for (int c = 0; c < 100 && !seen; c++) begin
                    @(negedge clock);
                    if (bus.busy) seen = 1'b1;
                end
                check("full_busy_seen", seen, 1);
                check("full_stored_before_busy", sent_count, 16);
                read_port(0, 22);
            end
        join
        check("full_drained", bus.vld_out_0, 0);
        check("full_error", bus.error, 0);

        // Second packet to a non-empty port waits for it to drain.
        send_pkt(2'd2, 1, 8'h40, 1'b0, 1'b1);
        fork
            send_pkt(2'd2, 2, 8'h50, 1'b0, 1'b1);
            begin
                repeat (4) @(negedge clock);
                check("wait_empty_busy", bus.busy, 1);
                read_port(2, 7);
            end
        join
        check("wait_empty_drained", bus.vld_out_2, 0);

`ifdef ROUTER_SOFT_RESET_EN
        send_pkt(2'd2, 2, 8'h60, 1'b0, 1'b1);
        repeat (31) @(posedge clock);
        #1;
        check("soft_rst_vld", bus.vld_out_2, 0);
        check("soft_rst_dout", bus.data_out_2, 0);
        exp_q[2].delete();
`else
        send_pkt(2'd2, 2, 8'h60, 1'b0, 1'b1);
        repeat (40) @(posedge clock);
        #1;
        check("hold_vld", bus.vld_out_2, 1);
        read_port(2, 4);
`endif

        // Reset mid-packet clears the partial FIFO contents and the FSM.
        drive_byte({6'd5, 2'd2}, 1'b1);
        drive_byte(8'h01, 1'b1);
        drive_byte(8'h02, 1'b1);
        bus.pkt_valid = 1'b0;
        resetn = 1'b1;
        @(posedge clock);
        #1;
        resetn = 1'b0;
        exp_q[2].delete();
        check("midrst_vld", {bus.vld_out_2, bus.vld_out_1, bus.vld_out_0}, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_dout2", bus.data_out_2, 0);
        send_pkt(2'd2, 0, 8'h00, 1'b0, 1'b1);
        read_port(2, 2);
        check("midrst_after_drained", bus.vld_out_2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
